// File: rtl/da_pkg.sv
// ============================================================================
// Module  : da_pkg
// Purpose : Shared types and constants for the DAC write arbiter slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package da_pkg;

  localparam int DA_DW = 8;
  localparam int DA_CW = 8;

  localparam int DA_SETUP_CYC_DEF = 1;
  localparam int DA_WR_CYC_DEF    = 3;
  localparam int DA_HOLD_CYC_DEF  = 1;
  localparam int DA_GAP_CYC_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } da_state_e;

endpackage

`default_nettype wire

// File: rtl/da_wr_arb_if.sv
// ============================================================================
// Module  : da_wr_arb_if
// Purpose : Requester handshakes plus DAC pin bundle; slave = arbiter side.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface da_wr_arb_if;
  import da_pkg::*;

  logic             req0;
  logic [DA_DW-1:0] din0;
  logic             ack0;
  logic             req1;
  logic [DA_DW-1:0] din1;
  logic             ack1;
  logic             cs;
  logic             wr;
  logic [DA_DW-1:0] dout;
  logic             busy;

  modport slave (
    input  req0, din0, req1, din1,
    output ack0, ack1, cs, wr, dout, busy
  );

  modport master (
    output req0, din0, req1, din1,
    input  ack0, ack1, cs, wr, dout, busy
  );

endinterface

`default_nettype wire

// File: rtl/da_rr_arb.sv
// ============================================================================
// Module  : da_rr_arb
// Purpose : 2-way round-robin arbiter; DA_WR_ARB_FIXED_PRIO_EN selects fixed
//           priority (req0 first) and removes the last-grant pointer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module da_rr_arb (
  input  wire        clk,
  input  wire        rst_n,
  input  wire  [1:0] req,
  input  wire        gnt_en,
  output logic [1:0] gnt
);

`ifdef DA_WR_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, gnt_en};

  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // r_last: index of the requester granted most recently
  logic r_last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_last <= 1'b1;
    else if (gnt_en && (|req))    r_last <= gnt[1];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/da_wr_arb.sv
// ============================================================================
// Module  : da_wr_arb
// Purpose : Two-requester arbiter and cs/wr strobe sequencer for the 8-bit
//           DAC. Build macro: DA_WR_ARB_FIXED_PRIO_EN (fixed priority).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module da_wr_arb
  import da_pkg::*;
#(
  parameter int SETUP_CYC = DA_SETUP_CYC_DEF,
  parameter int WR_CYC    = DA_WR_CYC_DEF,
  parameter int HOLD_CYC  = DA_HOLD_CYC_DEF,
  parameter int GAP_CYC   = DA_GAP_CYC_DEF
) (
  input  wire         clk,
  input  wire         rst_n,
  da_wr_arb_if.slave  bus
);

  localparam logic [DA_CW-1:0] c_setup_last = DA_CW'(SETUP_CYC - 1);
  localparam logic [DA_CW-1:0] c_wr_last    = DA_CW'(WR_CYC - 1);
  localparam logic [DA_CW-1:0] c_hold_last  = DA_CW'(HOLD_CYC - 1);
  localparam logic [DA_CW-1:0] c_gap_last   = DA_CW'(GAP_CYC - 1);
  localparam bit               c_no_gap     = (GAP_CYC == 0);

  da_state_e        r_state, w_state_nxt;
  logic [DA_CW-1:0] r_cnt, w_cnt_nxt;
  logic             r_cs, w_cs_nxt;
  logic             r_wr, w_wr_nxt;
  logic [DA_DW-1:0] r_dout, w_dout_nxt;
  logic             r_ack0, w_ack0_nxt;
  logic             r_ack1, w_ack1_nxt;
  logic [1:0]       w_gnt;
  logic             w_idle;

  assign w_idle = (r_state == IDLE);

  da_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req1, bus.req0}),
    .gnt_en (w_idle),
    .gnt    (w_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cs    <= 1'b1;
      r_wr    <= 1'b1;
      r_dout  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs    <= w_cs_nxt;
      r_wr    <= w_wr_nxt;
      r_dout  <= w_dout_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
    end
  end

  // r_cnt counts cycles spent in the current phase; it restarts at each transition
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_cs_nxt    = r_cs;
    w_wr_nxt    = r_wr;
    w_dout_nxt  = r_dout;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (|w_gnt) begin
          w_dout_nxt  = w_gnt[1] ? bus.din1 : bus.din0;
          w_ack0_nxt  = w_gnt[0];
          w_ack1_nxt  = w_gnt[1];
          w_cs_nxt    = 1'b0;
          w_state_nxt = SETUP;
        end
      end
      SETUP: if (r_cnt == c_setup_last) begin
        w_cnt_nxt   = '0;
        w_wr_nxt    = 1'b0;
        w_state_nxt = WRITE;
      end
      WRITE: if (r_cnt == c_wr_last) begin
        w_cnt_nxt   = '0;
        w_wr_nxt    = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: if (r_cnt == c_hold_last) begin
        w_cnt_nxt   = '0;
        w_cs_nxt    = 1'b1;
        w_state_nxt = c_no_gap ? IDLE : GAP;
      end
      GAP: if (r_cnt == c_gap_last) begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_cs_nxt    = 1'b1;
        w_wr_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cs   = r_cs;
  assign bus.wr   = r_wr;
  assign bus.dout = r_dout;
  assign bus.ack0 = r_ack0;
  assign bus.ack1 = r_ack1;
  assign bus.busy = !w_idle;

endmodule

`default_nettype wire

// File: tb/tb_da_wr_arb.sv
// ============================================================================
// Module  : tb_da_wr_arb
// Purpose : Bench for da_wr_arb: default-timing and minimum-timing instances
//           against a transaction-level timing model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_da_wr_arb;
  import da_pkg::*;

  int ps[2] = '{1, 1};
  int pw[2] = '{3, 1};
  int ph[2] = '{1, 1};
  int pg[2] = '{2, 0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  da_wr_arb_if ifa ();
  da_wr_arb_if ifb ();

  da_wr_arb u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  da_wr_arb #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1), .GAP_CYC(0))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic       req0_v [2];
  logic       req1_v [2];
  logic [7:0] din0_v [2];
  logic [7:0] din1_v [2];

  assign ifa.req0 = req0_v[0];
  assign ifa.din0 = din0_v[0];
  assign ifa.req1 = req1_v[0];
  assign ifa.din1 = din1_v[0];
  assign ifb.req0 = req0_v[1];
  assign ifb.din0 = din0_v[1];
  assign ifb.req1 = req1_v[1];
  assign ifb.din1 = din1_v[1];

  logic [1:0] cs_o, wr_o, ack0_o, ack1_o, busy_o;
  logic [7:0] dout_o [2];
  assign cs_o   = {ifb.cs,   ifa.cs};
  assign wr_o   = {ifb.wr,   ifa.wr};
  assign ack0_o = {ifb.ack0, ifa.ack0};
  assign ack1_o = {ifb.ack1, ifa.ack1};
  assign busy_o = {ifb.busy, ifa.busy};
  assign dout_o[0] = ifa.dout;
  assign dout_o[1] = ifb.dout;

  int n_assert;
  int n_fail;

  // Model: each write is a grant cycle; all pin timing is arithmetic on the
  // number of edges elapsed since that grant.
  int         cyc   [2];
  int         gcyc  [2];
  logic       mptr  [2];
  logic [7:0] mdout [2];
  logic       mack0 [2];
  logic       mack1 [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cyc[i]   = 0;
      gcyc[i]  = -1000;
      mptr[i]  = 1'b1;
      mdout[i] = 8'h00;
      mack0[i] = 1'b0;
      mack1[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i);
    int   period;
    logic win1;
    period = ps[i] + pw[i] + ph[i] + pg[i] + 1;
    cyc[i]++;
    mack0[i] = 1'b0;
    mack1[i] = 1'b0;
    if ((cyc[i] - gcyc[i] >= period) && (req0_v[i] || req1_v[i])) begin
`ifdef DA_WR_ARB_FIXED_PRIO_EN
      win1 = !req0_v[i];
`else
      win1 = (req0_v[i] && req1_v[i]) ? !mptr[i] : req1_v[i];
      mptr[i] = win1;
`endif
      gcyc[i]  = cyc[i];
      mdout[i] = win1 ? din1_v[i] : din0_v[i];
      mack0[i] = !win1;
      mack1[i] = win1;
    end
  endtask

  task automatic check_all();
    int t;
    for (int i = 0; i < 2; i++) begin
      t = cyc[i] - gcyc[i];
      chk($sformatf("u%0d.cs", i),   8'(cs_o[i]),   8'(!(t < ps[i] + pw[i] + ph[i])));
      chk($sformatf("u%0d.wr", i),   8'(wr_o[i]),   8'(!(t >= ps[i] && t < ps[i] + pw[i])));
      chk($sformatf("u%0d.busy", i), 8'(busy_o[i]), 8'(t < ps[i] + pw[i] + ph[i] + pg[i]));
      chk($sformatf("u%0d.dout", i), dout_o[i],     mdout[i]);
      chk($sformatf("u%0d.ack0", i), 8'(ack0_o[i]), 8'(mack0[i]));
      chk($sformatf("u%0d.ack1", i), 8'(ack1_o[i]), 8'(mack1[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic auto_req(input int i);
    if (req0_v[i] && mack0[i]) begin
      if ($urandom_range(1, 0) == 1) din0_v[i] = 8'($urandom);
      else                           req0_v[i] = 1'b0;
    end else if (!req0_v[i] && $urandom_range(3, 0) == 0) begin
      req0_v[i] = 1'b1;
      din0_v[i] = 8'($urandom);
    end
    if (req1_v[i] && mack1[i]) begin
      if ($urandom_range(1, 0) == 1) din1_v[i] = 8'($urandom);
      else                           req1_v[i] = 1'b0;
    end else if (!req1_v[i] && $urandom_range(3, 0) == 0) begin
      req1_v[i] = 1'b1;
      din1_v[i] = 8'($urandom);
    end
  endtask

  logic [7:0] exp_tie [4];
  int n_cs, n_wr, n_a0, n_a1, first_cs, first_wr, ng, last, hi, nb, t0, t1;
  logic seen;
  logic [7:0] got_dout;

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef DA_WR_ARB_FIXED_PRIO_EN
    exp_tie = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_tie = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
    for (int i = 0; i < 2; i++) begin
      req0_v[i] = 1'b0; req1_v[i] = 1'b0;
      din0_v[i] = 8'h00; din1_v[i] = 8'h00;
    end
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // single write with default timing
    req0_v[0] = 1'b1; din0_v[0] = 8'hA5;
    n_cs = 0; n_wr = 0; n_a0 = 0; n_a1 = 0; first_cs = -1; first_wr = -1;
    got_dout = 8'h00;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (ifa.ack0) begin n_a0++; got_dout = ifa.dout; end
      if (ifa.ack1) n_a1++;
      if (!ifa.cs) begin n_cs++; if (first_cs < 0) first_cs = k; end
      if (!ifa.wr) begin n_wr++; if (first_wr < 0) first_wr = k; end
      if (mack0[0]) req0_v[0] = 1'b0;
    end
    chk("single.cs_low",   8'(n_cs), 8'd5);
    chk("single.wr_low",   8'(n_wr), 8'd3);
    chk("single.wr_delay", 8'(first_wr - first_cs), 8'd1);
    chk("single.ack0_cnt", 8'(n_a0), 8'd1);
    chk("single.ack1_cnt", 8'(n_a1), 8'd0);
    chk("single.dout",     got_dout, 8'hA5);

    // tie from reset: alternation and 8-cycle grant spacing
    do_reset();
    req0_v[0] = 1'b1; din0_v[0] = 8'h11;
    req1_v[0] = 1'b1; din1_v[0] = 8'h22;
    ng = 0; last = -1;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      cycle();
      if (ifa.ack0 || ifa.ack1) begin
        chk($sformatf("tie.dout%0d", ng), ifa.dout, exp_tie[ng]);
        if (ng > 0) chk("tie.spacing", 8'(k - last), 8'd8);
        last = k; ng++;
      end
    end
    chk("tie.grants", 8'(ng), 8'd4);
    req0_v[0] = 1'b0; req1_v[0] = 1'b0;
    repeat (10) cycle();

    // minimum timing, back-to-back req0 on the second instance
    req0_v[1] = 1'b1; din0_v[1] = 8'h5A;
    last = -1; hi = 0; seen = 1'b0; nb = 0;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (ifb.ack0) begin
        if (last >= 0) chk("b2b.period", 8'(k - last), 8'd4);
        last = k; nb++;
      end
      if (!ifb.cs) begin
        if (seen && hi > 0) chk("b2b.cs_high", 8'(hi), 8'd1);
        hi = 0; seen = 1'b1;
      end else if (seen) begin
        hi++;
      end
    end
    chk("b2b.grants", 8'(nb), 8'd6);
    req0_v[1] = 1'b0;
    repeat (6) cycle();

    // req1 raised mid-WRITE waits for the first IDLE edge
    req0_v[0] = 1'b1; din0_v[0] = 8'h55;
    t0 = -1; t1 = -1;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (ifa.ack0 && t0 < 0) t0 = k;
      if (ifa.ack1 && t1 < 0) t1 = k;
      if (mack0[0]) req0_v[0] = 1'b0;
      if (mack1[0]) req1_v[0] = 1'b0;
      if (t0 >= 0 && k == t0 + 2) begin req1_v[0] = 1'b1; din1_v[0] = 8'h3C; end
    end
    chk("busy.ack1_delay", 8'(t1 - t0), 8'd8);

    // asynchronous reset while wr is low, req1 pending
    req0_v[0] = 1'b1; din0_v[0] = 8'h77;
    cycle();
    chk("rst.pre_ack0", 8'(ifa.ack0), 8'd1);
    req0_v[0] = 1'b0; req1_v[0] = 1'b1; din1_v[0] = 8'h3C;
    cycle();
    cycle();
    chk("rst.pre_wr", 8'(ifa.wr), 8'd0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("rst.cs",   8'(ifa.cs),   8'd1);
    chk("rst.wr",   8'(ifa.wr),   8'd1);
    chk("rst.dout", ifa.dout,     8'h00);
    chk("rst.busy", 8'(ifa.busy), 8'd0);
    check_all();
    cycle();
    rst_n = 1'b1;
    cycle();
    chk("rst.first_ack1", 8'(ifa.ack1), 8'd1);
    chk("rst.no_ack0",    8'(ifa.ack0), 8'd0);
    req1_v[0] = 1'b0;
    repeat (10) cycle();

    // idle: 100 cycles without requests
    n_a0 = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (ifa.ack0 || ifa.ack1 || ifb.ack0 || ifb.ack1) n_a0++;
    end
    chk("idle.acks",   8'(n_a0), 8'd0);
    chk("idle.dout_a", ifa.dout, 8'h3C);
    chk("idle.cs_a",   8'(ifa.cs), 8'd1);
    chk("idle.wr_a",   8'(ifa.wr), 8'd1);

    // randomized traffic on both instances
    for (int k = 0; k < 2000; k++) begin
      cycle();
      auto_req(0);
      auto_req(1);
    end
    for (int i = 0; i < 2; i++) begin
      req0_v[i] = 1'b0; req1_v[i] = 1'b0;
    end
    repeat (12) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
